word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 108 ++++++++++
 tb/tb_word_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: captures an N-bit word and emits it as N/W chunks,
// least-significant first, under valid/ready handshakes on both sides.
module word_serializer #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] d,
    input  logic         load_valid,
    output logic         load_ready,
    output logic [W-1:0] ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_last,
    output logic [15:0]  word_count
);

    localparam int CHUNKS = (W > 0) ? N / W : 1;
    localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    if (W < 1) begin : g_bad_chunk
        $error("word_serializer: W must be at least 1");
    end else if ((N % W) != 0 || N < W) begin : g_bad_ratio
        $error("word_serializer: N must be a non-zero integer multiple of W");
    end

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   count_q, count_d;
    logic          xfer;
    logic          load;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        count_d    = count_q;
        ser_valid  = 1'b0;
        load_ready = 1'b0;
        ser_last   = 1'b0;

        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid  = 1'b1;
                ser_last   = (idx_q == LAST_IDX);
                load_ready = ser_last && ser_ready;
            end
            default: ;
        endcase

        // The block must refuse words for as long as reset is held, not just after an edge.
        if (reset) begin
            load_ready = 1'b0;
        end

        xfer = ser_valid && ser_ready;
        load = load_valid && load_ready;

        if (xfer) begin
            shift_d = shift_q >> W;
            idx_d   = idx_q + 1'b1;
            if (ser_last) begin
                idx_d   = '0;
                count_d = count_q + 16'd1;
                state_d = IDLE;
            end
        end

        // A load on the final chunk's transfer overrides the return to IDLE: no bubble.
        if (load) begin
            shift_d = d;
            idx_d   = '0;
            state_d = SHIFT;
        end
    end

    assign ser_out    = shift_q[W-1:0];
    assign word_count = count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            // NOTE: the shift register is reset, not just the state, because ser_out must read 0 during reset.
            shift_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Randomized and directed bench for word_serializer against a chunk-queue reference model;
// a second N=W instance exercises single-chunk words and the word counter wrap.
module tb_word_serializer;

    localparam int N  = 32;
    localparam int W  = 8;
    localparam int NW = N / W;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  d;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  ser_out;
    logic          ser_valid;
    logic          ser_ready;
    logic          ser_last;
    logic [15:0]   word_count;

    logic [7:0]    d2;
    logic          load_valid2;
    logic          load_ready2;
    logic [7:0]    ser_out2;
    logic          ser_valid2;
    logic          ser_ready2;
    logic          ser_last2;
    logic [15:0]   word_count2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } chunk_t;

    chunk_t       exp_q[$];
    logic [W-1:0] log_q[$];
    int           m_count = 0;

    word_serializer #(.N(N), .W(W)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_last   (ser_last),
        .word_count (word_count)
    );

    word_serializer #(.N(8), .W(8)) u_wrap (
        .clock      (clock),
        .reset      (reset),
        .d          (d2),
        .load_valid (load_valid2),
        .load_ready (load_ready2),
        .ser_out    (ser_out2),
        .ser_valid  (ser_valid2),
        .ser_ready  (ser_ready2),
        .ser_last   (ser_last2),
        .word_count (word_count2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle on the main instance: apply inputs, compare outputs with the model,
    // then advance the model by the handshakes the rules say happen at this edge.
    task automatic cycle(input logic [N-1:0] dv, input logic lv, input logic sr);
        logic exp_valid, exp_ready;
        chunk_t c;
        d = dv; load_valid = lv; ser_ready = sr;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && sr);
        check("ser_valid", ser_valid, exp_valid);
        check("load_ready", load_ready, exp_ready);
        check("word_count", word_count, 32'(m_count[15:0]));
        if (exp_valid) begin
            check("ser_out", ser_out, exp_q[0].data);
            check("ser_last", ser_last, exp_q[0].last);
        end else begin
            check("ser_last_idle", ser_last, 1'b0);
        end
        if (exp_valid && sr) begin
            log_q.push_back(ser_out);
            if (exp_q[0].last) m_count++;
            void'(exp_q.pop_front());
        end
        if (lv && exp_ready) begin
            for (int k = 0; k < NW; k++) begin
                c.data = dv[W*k +: W];
                c.last = (k == NW - 1);
                exp_q.push_back(c);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_log(input string tag, input logic [63:0] exp_bytes, input int n);
        logic [63:0] e;
        e = exp_bytes;
        check({tag, "_len"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            check(tag, log_q[i], e[8*i +: 8]);
        end
        log_q.delete();
    endtask

    initial begin
        logic [7:0] prev;
        int start;

        reset = 1'b1;
        d = '0; load_valid = 1'b0; ser_ready = 1'b0;
        d2 = '0; load_valid2 = 1'b0; ser_ready2 = 1'b0;
        #1;
        check("rst_valid", ser_valid, 1'b0);
        check("rst_ready", load_ready, 1'b0);
        check("rst_out", ser_out, 8'h00);
        check("rst_last", ser_last, 1'b0);
        check("rst_count", word_count, 16'h0000);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", load_ready, 1'b1);

        // Single word with the consumer always ready.
        cycle(32'h11223344, 1'b1, 1'b1);
        repeat (NW) cycle(32'h0, 1'b0, 1'b1);
        check_log("single", 64'h11223344, 4);
        check("single_count", word_count, 16'd1);

        // Back-pressure on the second chunk.
        log_q.delete();
        cycle(32'h11223344, 1'b1, 1'b1);
        cycle(32'h0, 1'b0, 1'b1);
        repeat (3) begin
            cycle(32'h0, 1'b0, 1'b0);
            check("bp_hold_out", ser_out, 8'h33);
            check("bp_hold_valid", ser_valid, 1'b1);
        end
        repeat (3) cycle(32'h0, 1'b0, 1'b1);
        check_log("backpressure", 64'h11223344, 4);

        // Back-to-back words with load_valid held high.
        start = m_count;
        cycle(32'hAABBCCDD, 1'b1, 1'b1);
        repeat (NW - 1) cycle(32'h01020304, 1'b1, 1'b1);
        d = 32'h01020304; load_valid = 1'b1; ser_ready = 1'b1;
        #1;
        check("b2b_ready_on_last", load_ready, 1'b1);
        cycle(32'h01020304, 1'b1, 1'b1);
        repeat (NW) cycle(32'h0, 1'b0, 1'b1);
        check_log("b2b", {32'h01020304, 32'hAABBCCDD}, 8);
        check("b2b_count", word_count, 32'((start + 2) & 16'hFFFF));

        // d changing while no load is possible must not disturb the word in flight.
        cycle(32'hDEADBEEF, 1'b1, 1'b1);
        repeat (NW - 1) cycle($urandom, 1'b1, 1'b1);
        cycle($urandom, 1'b0, 1'b1);
        check_log("d_toggle", 64'hDEADBEEF, 4);

        // Randomized traffic, then drain.
        repeat (400) cycle($urandom, 1'($urandom_range(0, 1)), 1'(($urandom % 4) != 0));
        repeat (NW + 2) cycle(32'h0, 1'b0, 1'b1);
        check("drain_empty", exp_q.size(), 0);
        log_q.delete();

        // Asynchronous reset mid-word, between clock edges.
        cycle(32'h11223344, 1'b1, 1'b1);
        cycle(32'h0, 1'b0, 1'b1);
        cycle(32'h0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst_valid", ser_valid, 1'b0);
        check("midrst_count", word_count, 16'h0000);
        check("midrst_out", ser_out, 8'h00);
        check("midrst_ready", load_ready, 1'b0);
        exp_q.delete();
        log_q.delete();
        m_count = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(32'h55667788, 1'b1, 1'b1);
        repeat (NW) cycle(32'h0, 1'b0, 1'b1);
        check_log("after_rst", 64'h55667788, 4);
        check("after_rst_count", word_count, 16'd1);

        // Single-chunk words streamed back-to-back: every chunk is last, counter wraps.
        prev = 8'h00;
        load_valid2 = 1'b1;
        ser_ready2 = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            d2 = 8'($urandom);
            #1;
            if (i > 0) begin
                check("wrap_valid", ser_valid2, 1'b1);
                check("wrap_out", ser_out2, prev);
                check("wrap_last", ser_last2, 1'b1);
                if (i == 1 || i == 65536) check("wrap_count", word_count2, 32'((i - 1) & 16'hFFFF));
            end
            prev = d2;
            @(posedge clock);
            #1;
        end
        check("wrap_ffff_to_0", word_count2, 16'h0000);
        load_valid2 = 1'b0;
        #1;
        check("wrap_final_out", ser_out2, prev);
        @(posedge clock);
        #1;
        check("wrap_count_final", word_count2, 16'h0001);
        check("wrap_idle_valid", ser_valid2, 1'b0);
        check("wrap_idle_ready", load_ready2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
